// File: rtl/inst_prefetch_unit.sv
// Prefetch stage ahead of IF/ID: credit-limited in-order imem fetch into a DEPTH-entry FIFO; response -> inst_valid next cycle.
// dec_ready=0 holds the head and throttles issue at the credit limit. Perf counters built only with `PREFETCH_PERF_EN.

module inst_prefetch_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr_i,
  input  logic          push_i,
  input  logic [W-1:0]  push_dat_i,
  input  logic          pop_i,
  output logic [W-1:0]  head_o,
  output logic [CW-1:0] count_o
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  // Callers never pop when empty nor push when full.
  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (clr_i) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (push_i) wr_d = inc(wr_q);
      if (pop_i)  rd_d = inc(rd_q);
      if (push_i && !pop_i)      cnt_d = cnt_q + CW'(1);
      else if (pop_i && !push_i) cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !clr_i) mem_q[wr_q] <= push_dat_i;
  end

  assign head_o  = mem_q[rd_q];
  assign count_o = cnt_q;
endmodule

module inst_prefetch_unit #(
  parameter int          DEPTH     = 4,
  parameter int          MAX_OUTST = 2,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        dec_ready,
  output logic        inst_valid,
  output logic [31:0] inst_out,
  output logic [31:0] inst_pc,
  output logic [31:0] inst_pcplus4,
  output logic [31:0] perf_redirects,
  output logic [31:0] perf_bubbles
);
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int FCW = $clog2(DEPTH + 1);
  localparam int OCW = $clog2(MAX_OUTST + 1);

  logic [31:0]    fetch_pc_q, fetch_pc_d;
  logic [OCW-1:0] outst_q, outst_d, drop_q, drop_d;
  logic [31:0]    last_pc_q;
  logic [FCW-1:0] fifo_cnt;
  logic [63:0]    fifo_head;
  logic [31:0]    tag_pc;
  logic [OCW-1:0] unused_tag_cnt;
  logic           unused_bits;
  logic           issue, rsp_acc, fifo_push, fifo_pop;

  // Entries already buffered plus those in flight never exceed DEPTH, so pushes cannot overflow.
  assign imem_req_valid = reset && !redirect_valid
                       && (32'(fifo_cnt) + 32'(outst_q) < 32'(DEPTH))
                       && (32'(outst_q) < 32'(MAX_OUTST));
  assign imem_req_addr  = fetch_pc_q;
  assign issue          = imem_req_valid && imem_req_ready;
  assign rsp_acc        = imem_rsp_valid && (outst_q != '0);
  assign inst_valid     = (fifo_cnt != '0);
  assign fifo_pop       = inst_valid && dec_ready && !redirect_valid;
  assign fifo_push      = rsp_acc && (drop_q == '0) && !redirect_valid;
  assign unused_bits    = ^redirect_pc[1:0];

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    drop_d     = drop_q;
    outst_d    = outst_q;
    if (issue)   outst_d = outst_d + OCW'(1);
    if (rsp_acc) outst_d = outst_d - OCW'(1);
    if (redirect_valid) begin
      // Everything still in flight after this cycle belongs to the old path.
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
      drop_d     = outst_q - OCW'(rsp_acc);
    end else begin
      if (issue) fetch_pc_d = fetch_pc_q + 32'd4;
      if (rsp_acc && (drop_q != '0)) drop_d = drop_q - OCW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_q <= RESET_PC;
      outst_q    <= '0;
      drop_q     <= '0;
      last_pc_q  <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
      if (inst_valid) last_pc_q <= fifo_head[63:32];
    end
  end

  inst_prefetch_fifo #(.W(32), .DEPTH(MAX_OUTST), .CW(OCW)) u_tag_q (
    .clk        (clk),
    .reset      (reset),
    .clr_i      (1'b0),
    .push_i     (issue),
    .push_dat_i (fetch_pc_q),
    .pop_i      (rsp_acc),
    .head_o     (tag_pc),
    .count_o    (unused_tag_cnt)
  );

  inst_prefetch_fifo #(.W(64), .DEPTH(DEPTH), .CW(FCW)) u_inst_q (
    .clk        (clk),
    .reset      (reset),
    .clr_i      (redirect_valid),
    .push_i     (fifo_push),
    .push_dat_i ({tag_pc, imem_rsp_data}),
    .pop_i      (fifo_pop),
    .head_o     (fifo_head),
    .count_o    (fifo_cnt)
  );

  assign inst_out     = inst_valid ? fifo_head[31:0]  : NOP;
  assign inst_pc      = inst_valid ? fifo_head[63:32] : last_pc_q;
  assign inst_pcplus4 = inst_pc + 32'd4;

`ifdef PREFETCH_PERF_EN
  logic [31:0] perf_redir_q, perf_bub_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_redir_q <= '0;
      perf_bub_q   <= '0;
    end else begin
      if (redirect_valid && (perf_redir_q != '1)) perf_redir_q <= perf_redir_q + 32'd1;
      if (dec_ready && !inst_valid && (perf_bub_q != '1)) perf_bub_q <= perf_bub_q + 32'd1;
    end
  end

  assign perf_redirects = perf_redir_q;
  assign perf_bubbles   = perf_bub_q;
`else
  assign perf_redirects = '0;
  assign perf_bubbles   = '0;
`endif
endmodule

// File: tb/tb_inst_prefetch_unit.sv
// Randomized bench for inst_prefetch_unit against a queue-based reference model with an in-order variable-latency memory.
module tb_inst_prefetch_unit;
  localparam int          DEPTH     = 4;
  localparam int          MAX_OUTST = 2;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP       = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req_valid, imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        dec_ready = 1'b0;
  logic        inst_valid;
  logic [31:0] inst_out, inst_pc, inst_pcplus4, perf_redirects, perf_bubbles;

  int n_checks = 0;
  int n_errors = 0;

  inst_prefetch_unit #(.DEPTH(DEPTH), .MAX_OUTST(MAX_OUTST), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .dec_ready(dec_ready),
    .inst_valid(inst_valid), .inst_out(inst_out), .inst_pc(inst_pc), .inst_pcplus4(inst_pcplus4),
    .perf_redirects(perf_redirects), .perf_bubbles(perf_bubbles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Memory: in-order, per-request random latency, data is a hash of the address.
  typedef struct { logic [31:0] addr; int unsigned due; } mreq_t;
  mreq_t mq[$];
  int unsigned cyc = 0;
  int unsigned lat_lo = 1, lat_hi = 1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0033;
  endfunction

  // Reference model: decode queue, in-flight tags stamped with the fetch-path epoch.
  typedef struct { logic [31:0] pc; logic [31:0] dat; } ent_t;
  typedef struct { logic [31:0] pc; int epoch; } tag_t;
  ent_t fq[$];
  tag_t oq[$];
  int          epoch = 0;
  logic [31:0] m_fpc = RESET_PC;
  logic [31:0] m_last = '0;
  logic [31:0] m_pr = '0, m_pb = '0;
  int ph_req = 0, ph_bub = 0;

  task automatic evaluate();
    logic        e_rv, e_iv;
    logic [31:0] e_out, e_pc, e_pr, e_pb;
    tag_t        tg;
    if (!reset) begin
      chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
      chk("rst_inst_valid", 32'(inst_valid), 32'd0);
      chk("rst_inst_out", inst_out, NOP);
      chk("rst_inst_pc", inst_pc, 32'd0);
      chk("rst_pcplus4", inst_pcplus4, 32'd4);
      chk("rst_perf_redir", perf_redirects, 32'd0);
      chk("rst_perf_bub", perf_bubbles, 32'd0);
      fq.delete(); oq.delete();
      m_fpc = RESET_PC; m_last = '0; m_pr = '0; m_pb = '0;
      return;
    end
    e_rv  = !redirect_valid && (fq.size() + oq.size() < DEPTH) && (oq.size() < MAX_OUTST);
    e_iv  = fq.size() > 0;
    e_out = e_iv ? fq[0].dat : NOP;
    e_pc  = e_iv ? fq[0].pc : m_last;
`ifdef PREFETCH_PERF_EN
    e_pr = m_pr; e_pb = m_pb;
`else
    e_pr = '0; e_pb = '0;
`endif
    chk("req_valid", 32'(imem_req_valid), 32'(e_rv));
    if (e_rv) chk("req_addr", imem_req_addr, m_fpc);
    chk("inst_valid", 32'(inst_valid), 32'(e_iv));
    chk("inst_out", inst_out, e_out);
    chk("inst_pc", inst_pc, e_pc);
    chk("inst_pcplus4", inst_pcplus4, e_pc + 32'd4);
    chk("perf_redirects", perf_redirects, e_pr);
    chk("perf_bubbles", perf_bubbles, e_pb);

    if (imem_req_valid && imem_req_ready) begin
      mq.push_back('{addr: imem_req_addr, due: cyc + $urandom_range(lat_hi, lat_lo)});
      ph_req++;
    end
    if (dec_ready && !inst_valid) ph_bub++;

    if (redirect_valid && m_pr != '1) m_pr++;
    if (dec_ready && !e_iv && m_pb != '1) m_pb++;
    if (e_iv) m_last = fq[0].pc;
    if (redirect_valid) begin
      if (imem_rsp_valid && oq.size() > 0) oq.delete(0);
      fq.delete();
      epoch++;
      m_fpc = redirect_pc & ~32'h3;
    end else begin
      if (e_iv && dec_ready) fq.delete(0);
      if (imem_rsp_valid && oq.size() > 0) begin
        tg = oq[0];
        oq.delete(0);
        if (tg.epoch == epoch) fq.push_back('{pc: tg.pc, dat: imem_rsp_data});
      end
      if (e_rv && imem_req_ready) begin
        oq.push_back('{pc: m_fpc, epoch: epoch});
        m_fpc = m_fpc + 32'd4;
      end
    end
  endtask

  task automatic step(input logic rst_n, input logic r, input logic [31:0] rpc,
                      input logic rdy, input logic dr);
    @(posedge clk); #1;
    reset = rst_n; redirect_valid = r; redirect_pc = rpc;
    imem_req_ready = rdy; dec_ready = dr;
    imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(mq[0].addr);
      mq.delete(0);
    end
    @(negedge clk);
    evaluate();
    cyc++;
  endtask

  initial begin
    repeat (3) step(0, 0, 0, 0, 0);

    // Free-running fetch, 1-cycle memory: no bubbles once the first instruction lands.
    step(1, 0, 0, 1, 1); step(1, 0, 0, 1, 1);
    ph_bub = 0;
    repeat (18) step(1, 0, 0, 1, 1);
    chk("fill_bubbles", 32'(ph_bub), 32'd0);

    // Decode stalled: credit limit caps issue at DEPTH requests, then drains in order.
    repeat (2) step(0, 0, 0, 0, 0);
    ph_req = 0;
    repeat (10) step(1, 0, 0, 1, 0);
    chk("stall_reqs", 32'(ph_req), 32'd4);
    chk("stall_req_valid", 32'(imem_req_valid), 32'd0);
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 0, 0, 1);
      chk("drain_pc", inst_pc, 32'(i * 4));
    end
    step(1, 0, 0, 0, 1);
    chk("drain_empty", 32'(inst_valid), 32'd0);

    // Two requests in flight (0x10, 0x14) when a redirect to 0x102 arrives.
    lat_lo = 5; lat_hi = 5;
    step(1, 0, 0, 1, 1); step(1, 0, 0, 1, 1);
    step(1, 1, 32'h0000_0102, 1, 1);
    lat_lo = 1; lat_hi = 1;
    step(1, 0, 0, 1, 1);
    chk("redir_addr", imem_req_addr, 32'h0000_0100);
    for (int i = 0; i < 30 && !inst_valid; i++) step(1, 0, 0, 1, 1);
    chk("redir_first_valid", 32'(inst_valid), 32'd1);
    chk("redir_first_pc", inst_pc, 32'h0000_0100);
    chk("redir_first_pc4", inst_pcplus4, 32'h0000_0104);

    // Redirect coinciding with a response and a pop.
    repeat (6) step(1, 0, 0, 1, 1);
    chk("pre_redir_valid", 32'(inst_valid), 32'd1);
    step(1, 1, 32'h0000_0200, 1, 1);
    step(1, 0, 0, 1, 1);
    chk("redir_flush_empty", 32'(inst_valid), 32'd0);

    // Reset with two requests outstanding; late responses must be ignored.
    lat_lo = 4; lat_hi = 4;
    repeat (2) step(0, 0, 0, 0, 0);
    step(1, 0, 0, 1, 1); step(1, 0, 0, 1, 1);
    step(0, 0, 0, 0, 0); step(0, 0, 0, 0, 0);
    repeat (6) step(1, 0, 0, 0, 1);
    chk("late_rsp_valid", 32'(inst_valid), 32'd0);
    chk("late_rsp_nop", inst_out, NOP);
    lat_lo = 1; lat_hi = 1;
    for (int i = 0; i < 20 && !inst_valid; i++) step(1, 0, 0, 1, 1);
    chk("post_rst_valid", 32'(inst_valid), 32'd1);
    chk("post_rst_pc", inst_pc, RESET_PC);

    // Five empty-while-ready cycles, then three redirects.
    repeat (2) step(0, 0, 0, 0, 0);
    repeat (5) step(1, 0, 0, 0, 1);
    repeat (3) step(1, 1, 32'h0000_0040, 0, 0);
    step(1, 0, 0, 0, 0);
`ifdef PREFETCH_PERF_EN
    chk("perf_redir_cnt", perf_redirects, 32'd3);
    chk("perf_bub_cnt", perf_bubbles, 32'd5);
`else
    chk("perf_redir_off", perf_redirects, 32'd0);
    chk("perf_bub_off", perf_bubbles, 32'd0);
`endif

    lat_lo = 1; lat_hi = 4;
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 199) != 0), ($urandom_range(0, 19) == 0), $urandom,
           ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/inst_prefetch_unit.md
Name: inst_prefetch_unit

Overview:
- Fetch-side stage that sits directly upstream of the IF/ID pipeline register.
- Issues in-order instruction requests to a variable-latency instruction memory using a valid/ready request channel and a valid-only response channel.
- Buffers returned instructions with their PCs in a small FIFO and presents one instruction per cycle to decode.
- Handles branch/jump redirects, including discarding responses that are still in flight.

Parameters:
- DEPTH, 4, instruction FIFO entries (power of 2, >=2).
- MAX_OUTST, 2, maximum in-flight imem requests (power of 2, >=1).
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- imem_req_valid  out  1  request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  32  word-aligned fetch address.
- imem_rsp_valid  in  1  response valid; responses return in request order.
- imem_rsp_data  in  32  instruction word.
- redirect_valid  in  1  taken branch/jump from EX (PCSrc).
- redirect_pc  in  32  target address (PCTarget).
- dec_ready  in  1  decode can accept (= !StallD).
- inst_valid  out  1  inst_out is valid.
- inst_out  out  32  instruction to the IF/ID register.
- inst_pc  out  32  PC of inst_out.
- inst_pcplus4  out  32  inst_pc + 4.
- perf_redirects  out  32  see Optional Feature.
- perf_bubbles  out  32  see Optional Feature.

Behaviour:
- Reset (reset=0, asynchronous):
  - fetch_pc=RESET_PC; FIFO empty; outstanding=0; drop_cnt=0.
  - imem_req_valid=0, inst_valid=0, inst_out=32'h0000_0013 (NOP), inst_pc=0, inst_pcplus4=4, perf counters=0.
  - Responses arriving while outstanding=0 are ignored; this covers reset mid-transaction.
- Issue:
  - imem_req_valid = !redirect_valid && (fifo_count + outstanding < DEPTH) && (outstanding < MAX_OUTST); imem_req_addr=fetch_pc.
  - On valid&&ready: push fetch_pc into the tag queue, outstanding+1, fetch_pc+=4 (32-bit wrap, 0xFFFF_FFFC -> 0).
  - While valid && !ready, addr holds stable unless a redirect occurs.
- Response:
  - On imem_rsp_valid with outstanding>0: pop the tag queue and decrement outstanding.
  - If drop_cnt>0: discard the response and decrement drop_cnt.
  - Otherwise: push {tag_pc, data} into the FIFO.
  - The credit rule guarantees the FIFO never overflows.
  - Issue and response in the same cycle: outstanding is unchanged.
- Output:
  - inst_valid = FIFO non-empty; inst_out/inst_pc are the head entry, combinational from storage.
  - When the FIFO is empty, inst_out is NOP and inst_pc holds its last value.
  - Pop on inst_valid && dec_ready && !redirect_valid.
  - Latency: a response in cycle N is visible on inst_valid in cycle N+1.
- Redirect (redirect_valid=1 in cycle N):
  - FIFO cleared at the N edge.
  - fetch_pc=redirect_pc with bits[1:0] forced to 0.
  - No request issued in cycle N.
  - drop_cnt = outstanding minus (1 if a response is accepted in N).
  - A response arriving in N is always discarded.
  - A pop in N is suppressed; redirect wins over pop and over push.
  - Back-to-back redirects: each one reloads fetch_pc and recomputes drop_cnt.
- Stall:
  - dec_ready=0 holds the head entry.
  - Fetch continues until the credit limit, then imem_req_valid drops.

Optional Feature:
- Macro: PREFETCH_PERF_EN.
- Defined:
  - perf_redirects increments on each cycle with redirect_valid=1.
  - perf_bubbles increments each cycle with dec_ready=1 && inst_valid=0 && reset released.
  - Both counters saturate at 32'hFFFF_FFFF.
- Undefined: both ports are driven constant 0 and no counter flops are built.

Test Plan:
- Reset release, memory always ready, 1-cycle latency, dec_ready=1 -> requests 0x0, 0x4, 0x8...; inst_pc sequence 0x0, 0x4, 0x8 with no bubbles after the first fill; inst_pcplus4 = inst_pc+4.
- dec_ready=0 for 10 cycles, DEPTH=4, MAX_OUTST=2 -> exactly 4 requests issued, imem_req_valid=0 afterwards; on release the FIFO drains 0x0..0xC in order.
- Two requests in flight (0x10, 0x14), redirect to 0x102 -> both responses dropped; next request addr 0x100; first inst_pc after redirect is 0x100.
- Redirect in the same cycle as a response and a pop -> response dropped, no pop, FIFO empty next cycle, drop_cnt = outstanding-1.
- Assert reset low mid-flight with 2 outstanding, then deassert; memory returns 2 late responses -> responses ignored, first inst_pc is RESET_PC, inst_out is NOP until the first valid response.
- With PREFETCH_PERF_EN: 3 redirects plus 5 empty-while-ready cycles -> perf_redirects=3, perf_bubbles=5. Without the macro -> both ports read 0.
